// File: rtl/getin_pkg.sv
// getin_pkg: shared constants and types for the getin source FIFO.
//   GETIN_WIDTH  data word width (matches the processor getin port)
//   GETIN_DEPTH  buffer entries (power of two, >= 2)
package getin_pkg;
   localparam int GETIN_WIDTH = 16;
   localparam int GETIN_DEPTH = 4;

   typedef logic [GETIN_WIDTH-1:0] getin_word_t;
endpackage

// File: rtl/getin_source_fifo_if.sv
// getin_source_fifo_if: bus between the external word source / processor
// and the getin source FIFO.
//   in_data/in_valid/in_ready   push side from the external source
//   getin/getin_valid/getin_ack pop side toward the processor
//   count                       words currently buffered
//   underflow                   sticky: ack seen while empty
// Modports: slave = the FIFO, master = the environment driving it.
interface getin_source_fifo_if
   import getin_pkg::*;
#(
   parameter int WIDTH = GETIN_WIDTH,
   parameter int DEPTH = GETIN_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] getin;
   logic             getin_valid;
   logic             getin_ack;
   logic [AW:0]      count;
   logic             underflow;

   modport slave (
      input  in_data, in_valid, getin_ack,
      output in_ready, getin, getin_valid, count, underflow
   );

   modport master (
      output in_data, in_valid, getin_ack,
      input  in_ready, getin, getin_valid, count, underflow
   );
endinterface

// File: rtl/getin_source_fifo.sv
// getin_source_fifo: first-word-fall-through buffer feeding the stack
// processor's getin port. Words pushed by an external source appear on
// getin one cycle later; the processor pops the head with a one-cycle ack.
// Ports:
//   CLK    system clock, rising edge
//   reset  synchronous, active-high; empties the buffer, clears underflow
//   bus    getin_source_fifo_if.slave (push side, pop side, count, underflow)
// Build option: GETIN_HOLD_LAST_EN - when defined, getin keeps showing the
// last consumed word while the buffer is empty (0 until the first pop);
// otherwise getin is 0 while empty.
module getin_source_fifo
   import getin_pkg::*;
#(
   parameter int WIDTH = GETIN_WIDTH,
   parameter int DEPTH = GETIN_DEPTH
) (
   input  logic                 CLK,
   input  logic                 reset,
   getin_source_fifo_if.slave   bus
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             underflow_q, underflow_d;
   logic             empty, push, pop;

   assign empty = (count_q == '0);

   // Readiness depends only on occupancy, so a pop in the same cycle as a
   // full buffer does not open a slot until the next cycle.
   assign bus.in_ready    = !reset && (count_q != FULL);
   assign bus.getin_valid = !empty;
   assign bus.count       = count_q;
   assign bus.underflow   = underflow_q;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.getin_ack && !empty;

   // Pointers are AW bits wide and DEPTH is a power of two, so increments
   // wrap from DEPTH-1 to 0 on their own. Full/empty come from count only.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      underflow_d = underflow_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (bus.getin_ack && empty) underflow_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not cleared by reset; push is already gated by reset.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
   end

`ifdef GETIN_HOLD_LAST_EN
   logic [WIDTH-1:0] last_q;

   always_ff @(posedge CLK) begin
      if (reset)    last_q <= '0;
      else if (pop) last_q <= mem_q[rd_ptr_q];
   end

   assign bus.getin = empty ? last_q : mem_q[rd_ptr_q];
`else
   assign bus.getin = empty ? '0 : mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_getin_source_fifo.sv
// tb_getin_source_fifo: directed test-plan sequences plus randomized traffic
// against a queue-based reference model, compared every cycle.
module tb_getin_source_fifo;
   import getin_pkg::*;

   localparam int DEPTH = GETIN_DEPTH;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   getin_source_fifo_if bus ();

   getin_source_fifo dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   // Reference model: a queue of words, a sticky flag, the last popped word.
   getin_word_t m_q[$];
   bit          m_uf;
   getin_word_t m_last;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge CLK) begin
      bit can_push, do_push, do_pop, ack_empty;
      if (reset) begin
         m_q.delete();
         m_uf   = 1'b0;
         m_last = '0;
      end else begin
         can_push  = (m_q.size() != DEPTH);
         do_push   = bus.in_valid && can_push;
         do_pop    = bus.getin_ack && (m_q.size() != 0);
         ack_empty = bus.getin_ack && (m_q.size() == 0);
         if (ack_empty) m_uf = 1'b1;
         if (do_pop)    m_last = m_q.pop_front();
         if (do_push)   m_q.push_back(bus.in_data);
      end
   end

   function automatic getin_word_t exp_getin();
      if (m_q.size() != 0) return m_q[0];
`ifdef GETIN_HOLD_LAST_EN
      return m_last;
`else
      return '0;
`endif
   endfunction

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("cyc_in_ready",    bus.in_ready,    (!reset && m_q.size() != DEPTH));
         chk("cyc_getin_valid", bus.getin_valid, (m_q.size() != 0));
         chk("cyc_count",       bus.count,       m_q.size());
         chk("cyc_underflow",   bus.underflow,   m_uf);
         chk("cyc_getin",       bus.getin,       exp_getin());
      end
   end

   // Apply inputs for one edge, then return #1 after that edge with inputs idle.
   task automatic cyc(input bit v, input int d, input bit a);
      bus.in_valid  = v;
      bus.in_data   = getin_word_t'(d);
      bus.getin_ack = a;
      @(posedge CLK);
      #1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.getin_ack = 1'b0;
   endtask

   initial begin
      int p_push, p_ack;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.getin_ack = 1'b0;
      @(posedge CLK);
      #1;
      chk("rst_in_ready_low", bus.in_ready, 0);
      cyc(0, 0, 0);
      reset  = 1'b0;
      #1;
      cmp_en = 1'b1;
      chk("rst_count", bus.count, 0);
      chk("rst_valid", bus.getin_valid, 0);
      chk("rst_getin", bus.getin, 0);
      chk("rst_uf", bus.underflow, 0);
      chk("rst_in_ready", bus.in_ready, 1);

      // single word, one-cycle latency
      cyc(1, 30030, 0);
      chk("t1_getin", bus.getin, 30030);
      chk("t1_valid", bus.getin_valid, 1);
      chk("t1_count", bus.count, 1);
      cyc(0, 0, 1);
      chk("t1_valid_after_ack", bus.getin_valid, 0);
      chk("t1_count_after_ack", bus.count, 0);

      // fill, refuse, drain in order
      for (int i = 1; i <= 4; i++) cyc(1, i, 0);
      chk("t2_count_full", bus.count, 4);
      chk("t2_in_ready_full", bus.in_ready, 0);
      cyc(1, 5, 0);
      chk("t2_count_refused", bus.count, 4);
      for (int i = 1; i <= 4; i++) begin
         chk("t2_order", bus.getin, i);
         cyc(0, 0, 1);
      end
      chk("t2_count_drained", bus.count, 0);

      // push+ack at full: pop only
      for (int i = 21; i <= 24; i++) cyc(1, i, 0);
      cyc(1, 9, 1);
      chk("t3_count", bus.count, 3);
      chk("t3_in_ready", bus.in_ready, 1);
      chk("t3_head", bus.getin, 22);
      cyc(1, 9, 0);
      chk("t3_count_refill", bus.count, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_order", bus.getin, (i < 3) ? 22 + i : 9);
         cyc(0, 0, 1);
      end

      // streaming across pointer wrap
      cyc(1, 10, 0);
      for (int i = 11; i <= 19; i++) begin
         chk("t4_stream", bus.getin, i - 1);
         cyc(1, i, 1);
         chk("t4_count", bus.count, 1);
      end
      chk("t4_last", bus.getin, 19);
      cyc(0, 0, 1);
      chk("t4_empty", bus.count, 0);

      // underflow is sticky
      cyc(0, 0, 1);
      chk("t5_uf", bus.underflow, 1);
      chk("t5_count", bus.count, 0);
      cyc(1, 50, 0);
      chk("t5_ptr_intact", bus.getin, 50);
      cyc(0, 0, 1);
      chk("t5_uf_sticky", bus.underflow, 1);

      // empty getin value
      cyc(1, 7, 0);
      cyc(0, 0, 1);
`ifdef GETIN_HOLD_LAST_EN
      chk("t6_hold", bus.getin, 7);
`else
      chk("t6_zero", bus.getin, 0);
`endif
      chk("t6_valid", bus.getin_valid, 0);

      // reset mid-stream
      for (int i = 1; i <= 3; i++) cyc(1, 100 + i, 0);
      reset = 1'b1;
      cyc(0, 0, 0);
      reset = 1'b0;
      #1;
      chk("t7_count", bus.count, 0);
      chk("t7_valid", bus.getin_valid, 0);
      chk("t7_in_ready", bus.in_ready, 1);
      chk("t7_uf", bus.underflow, 0);

      // randomized traffic with biased phases to reach full and empty
      p_push = 5;
      p_ack  = 5;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            p_push = $urandom_range(1, 9);
            p_ack  = $urandom_range(1, 9);
         end
         reset = ($urandom_range(0, 199) == 0);
         cyc($urandom_range(0, 9) < p_push, $urandom_range(0, 65535),
             $urandom_range(0, 9) < p_ack);
      end
      reset = 1'b0;
      cyc(0, 0, 0);
      @(posedge CLK);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
